shift_reg_seq: RTL

Command sequencer that drives the mode, serial-fill and parallel-load inputs of the 8-bit universal shift register (shift_reg_8b).
- Accepts one command at a time over a valid/ready handshake: load, shift left N, shift right N, or wait N.
- Holds the register mode for exactly the commanded number of clock edges, then returns it to hold.
- Captures the register output Q into a result register and pulses done.

---
 rtl/shift_reg_seq_if.sv | 31 +++
 rtl/shift_reg_seq.sv | 89 ++++++++
 2 files changed

// File: rtl/shift_reg_seq_if.sv
// Command and shift-register bus of the shift_reg_seq sequencer.
// master drives commands and the register's Q; slave is the sequencer itself.
interface shift_reg_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cmd_fill;
    logic [WIDTH-1:0] cmd_data;
    logic [1:0]       s;
    logic             SDL;
    logic             SDR;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data, Q,
        input  cmd_ready, s, SDL, SDR, D, busy, done, result
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_fill, cmd_data, Q,
        output cmd_ready, s, SDL, SDR, D, busy, done, result
    );
endinterface

// File: rtl/shift_reg_seq.sv
// Sequencer for an 8-bit universal shift register: runs one load/shift/wait
// command at a time and captures the register output when it completes.
module shift_reg_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic            CLK,
    input  logic            CLRb,
    shift_reg_seq_if.slave  bus
);
    localparam logic [1:0] OpWait  = 2'b00;
    localparam logic [1:0] OpShr   = 2'b01;
    localparam logic [1:0] OpShl   = 2'b10;
    localparam logic [1:0] OpLoad  = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StCapture} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       s_q;
    logic             sdl_q;
    logic             sdr_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;

    always_ff @(posedge CLK or negedge CLRb) begin
        if (!CLRb) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            s_q      <= OpWait;
            sdl_q    <= 1'b0;
            sdr_q    <= 1'b0;
            d_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        s_q   <= bus.cmd_op;
                        sdl_q <= (bus.cmd_op == OpShl) ? bus.cmd_fill : 1'b0;
                        sdr_q <= (bus.cmd_op == OpShr) ? bus.cmd_fill : 1'b0;
                        if (bus.cmd_op == OpLoad) begin
                            d_q   <= bus.cmd_data;
                            cnt_q <= CNT_W'(1);
                        end else begin
                            cnt_q <= bus.cmd_cnt;
                        end
                        // A zero-length shift/wait never leaves hold.
                        if (bus.cmd_op != OpLoad && bus.cmd_cnt == '0) begin
                            s_q     <= OpWait;
                            sdl_q   <= 1'b0;
                            sdr_q   <= 1'b0;
                            state_q <= StCapture;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        s_q     <= OpWait;
                        sdl_q   <= 1'b0;
                        sdr_q   <= 1'b0;
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    result_q <= bus.Q;
                    done_q   <= 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.s         = s_q;
    assign bus.SDL       = sdl_q;
    assign bus.SDR       = sdr_q;
    assign bus.D         = d_q;
    assign bus.result    = result_q;
    assign bus.done      = done_q;
endmodule
